l1_trig_wb_intercon: RTL and testbench
======================================

// Module: l1_trig_wb_intercon
// PURPOSE
//  Wishbone 1:4 address-decoding interconnect for the L1 trigger block.
//  A single WB host (15-bit address, 32-bit data) is split into four 8 KiB
//  subspaces: threshold, generator (control), AGC and biquad.
//  While the interface clock is stopped, it shields the host from the
//  ifclk-domain targets. Sits between the SURF WB bus and the L1 trigger
//  submodules.
// PARAMETERS
//  ADR_W     15  host address width; subspace select = adr[ADR_W-1 -: 2]
//  DAT_W     32  data width (SEL width = DAT_W/8)
//  DEAD_DATA 32'hDEAD_C10C  read data returned for shielded accesses
//  TIMEOUT   256 watchdog cycles (only with L1_INTERCON_TIMEOUT_EN)
// PORTS
//  wb_clk_i          in   1      single clock, all logic on rising edge
//  wb_rst_i          in   1      asynchronous, active-low reset
//  clock_enabled_i   in   1      ifclk running; sampled at transaction start
//  wb_cyc_i/stb_i/we_i in 1 each host WB classic strobes
//  wb_adr_i          in   15     host byte address
//  wb_dat_i          in   32     host write data
//  wb_sel_i          in   4      byte enables
//  wb_ack_o/err_o/rty_o out 1 each host termination, one-cycle pulses
//  wb_dat_o          out  32     read data, valid with wb_ack_o
//  <p>_cyc_o/stb_o/we_o out 1 each target strobes, p = thresh,control,agc,bq
//  <p>_adr_o         out  13     wb_adr_i[12:0]
//  <p>_dat_o, <p>_sel_o out 32/4 forwarded write data / byte enables
//  <p>_ack_i/err_i/rty_i in 1 each target termination
//  <p>_dat_i         in   32     target read data
// BEHAVIOUR
//  - Decode adr[14:13]: 0=thresh 0x0000, 1=control 0x2000, 2=agc 0x4000,
//    3=bq 0x6000. Only the selected target ever sees cyc/stb.
//  - FSM IDLE->BUSY->ACK->IDLE. All outputs are registered.
//  - IDLE: on cyc&stb, latch sel/adr/dat/we/sel.
//    - If target 0/1 and clock_enabled_i=0: go ACK, wb_dat_o=DEAD_DATA,
//      writes discarded. Target strobes never asserted.
//    - Otherwise: assert target cyc/stb next edge and go BUSY.
//  - BUSY: first cycle with the target's ack|err|rty: drop target cyc/stb
//    on the same edge, latch <p>_dat_i, go ACK.
//    - Mirror the termination: ack->wb_ack_o, err->wb_err_o, rty->wb_rty_o.
//    - Priority on simultaneous terminations: err > rty > ack.
//  - ACK: exactly one termination pulse for one cycle, then IDLE.
//  - Back-to-back: host still cyc&stb in IDLE starts a new transaction.
//    Minimum host-visible latency: 3 cycles from strobe to termination,
//    with a target acking in its first cycle.
//  - Abort: wb_cyc_i low in BUSY drops the target cyc/stb next edge and
//    returns to IDLE with no termination. Late target acks are ignored.
//  - Reset: all outputs 0, wb_dat_o=0, FSM IDLE. Reset asserted
//    mid-transaction drops target strobes immediately (async).
//  - Non-selected targets' responses are ignored at all times.
//  - A clock_enabled_i change mid-BUSY has no effect on the transaction
//    in flight.
// CONFIGURATION
//  L1_INTERCON_TIMEOUT_EN defined:
//    - 8-bit counter runs in BUSY. At TIMEOUT cycles without a target
//      response: drop target strobes, pulse wb_err_o, wb_dat_o=DEAD_DATA,
//      return to IDLE.
//  Undefined:
//    - No counter; BUSY waits indefinitely for the target.
// TESTING
//  1. Read 0x4010, agc_ack_i 1 cycle later with 0x12345678 ->
//     agc_adr_o=0x0010, wb_ack_o 1 pulse, wb_dat_o=0x12345678;
//     other targets' cyc stay 0.
//  2. Write 0x6004 data 0xA5A5A5A5 sel 0xF -> bq_we_o=1,
//     bq_dat_o=0xA5A5A5A5, bq_adr_o=0x0004, ack returned.
//  3. clock_enabled_i=0, read 0x2000 -> no control_cyc_o, wb_ack_o after
//     2 cycles, wb_dat_o=0xDEADC10C. Same access to 0x4000 still reaches agc.
//  4. thresh_err_i and thresh_ack_i asserted together -> wb_err_o=1,
//     wb_ack_o=0.
//  5. Drop wb_cyc_i while BUSY on generator -> control_cyc_o=0 next cycle,
//    no termination. A later control_ack_i produces no wb_ack_o.
//  6. Timeout enabled, silent agc target -> wb_err_o at BUSY cycle 256,
//     agc_cyc_o cleared. Timeout disabled -> still BUSY after 1000 cycles.

Source files
------------

// File: rtl/l1_trig_wb_intercon.sv
// Wishbone 1:4 address-decoding interconnect for the L1 trigger block (thresh/control/agc/bq).
// Optional watchdog on stalled targets: define L1_INTERCON_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for host cyc&stb
// BUSY  | selected target strobed, waiting for its termination
// ACK   | presenting one termination pulse to the host
module l1_trig_wb_intercon #(
    parameter int ADR_W = 15,
    parameter int DAT_W = 32,
    parameter logic [DAT_W-1:0] DEAD_DATA = 32'hDEAD_C10C
`ifdef L1_INTERCON_TIMEOUT_EN
    , parameter int TIMEOUT = 256
`endif
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               clock_enabled_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [ADR_W-1:0]   wb_adr_i,
    input  logic [DAT_W-1:0]   wb_dat_i,
    input  logic [DAT_W/8-1:0] wb_sel_i,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    output logic [DAT_W-1:0]   wb_dat_o,

    output logic               thresh_cyc_o,
    output logic               thresh_stb_o,
    output logic               thresh_we_o,
    output logic [ADR_W-3:0]   thresh_adr_o,
    output logic [DAT_W-1:0]   thresh_dat_o,
    output logic [DAT_W/8-1:0] thresh_sel_o,
    input  logic               thresh_ack_i,
    input  logic               thresh_err_i,
    input  logic               thresh_rty_i,
    input  logic [DAT_W-1:0]   thresh_dat_i,

    output logic               control_cyc_o,
    output logic               control_stb_o,
    output logic               control_we_o,
    output logic [ADR_W-3:0]   control_adr_o,
    output logic [DAT_W-1:0]   control_dat_o,
    output logic [DAT_W/8-1:0] control_sel_o,
    input  logic               control_ack_i,
    input  logic               control_err_i,
    input  logic               control_rty_i,
    input  logic [DAT_W-1:0]   control_dat_i,

    output logic               agc_cyc_o,
    output logic               agc_stb_o,
    output logic               agc_we_o,
    output logic [ADR_W-3:0]   agc_adr_o,
    output logic [DAT_W-1:0]   agc_dat_o,
    output logic [DAT_W/8-1:0] agc_sel_o,
    input  logic               agc_ack_i,
    input  logic               agc_err_i,
    input  logic               agc_rty_i,
    input  logic [DAT_W-1:0]   agc_dat_i,

    output logic               bq_cyc_o,
    output logic               bq_stb_o,
    output logic               bq_we_o,
    output logic [ADR_W-3:0]   bq_adr_o,
    output logic [DAT_W-1:0]   bq_dat_o,
    output logic [DAT_W/8-1:0] bq_sel_o,
    input  logic               bq_ack_i,
    input  logic               bq_err_i,
    input  logic               bq_rty_i,
    input  logic [DAT_W-1:0]   bq_dat_i
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t             state;
    logic [1:0]         tgt;
    logic [3:0]         tgt_cyc;
    logic [ADR_W-3:0]   lat_adr;
    logic [DAT_W-1:0]   lat_dat;
    logic [DAT_W/8-1:0] lat_sel;
    logic               lat_we;
    logic               pend_err;
    logic               pend_rty;

    logic [3:0]         t_ack, t_err, t_rty;
    logic               sel_ack, sel_err, sel_rty;
    logic [DAT_W-1:0]   sel_dat;
    logic               term_out;

`ifdef L1_INTERCON_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign t_ack = {bq_ack_i, agc_ack_i, control_ack_i, thresh_ack_i};
    assign t_err = {bq_err_i, agc_err_i, control_err_i, thresh_err_i};
    assign t_rty = {bq_rty_i, agc_rty_i, control_rty_i, thresh_rty_i};
    assign term_out = wb_ack_o | wb_err_o | wb_rty_o;

    always_comb begin
        sel_ack = t_ack[tgt];
        sel_err = t_err[tgt];
        sel_rty = t_rty[tgt];
        sel_dat = thresh_dat_i;
        case (tgt)
            2'd0: sel_dat = thresh_dat_i;
            2'd1: sel_dat = control_dat_i;
            2'd2: sel_dat = agc_dat_i;
            2'd3: sel_dat = bq_dat_i;
            default: sel_dat = thresh_dat_i;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= IDLE;
            tgt      <= 2'd0;
            tgt_cyc  <= 4'b0;
            lat_adr  <= '0;
            lat_dat  <= '0;
            lat_sel  <= '0;
            lat_we   <= 1'b0;
            pend_err <= 1'b0;
            pend_rty <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_rty_o <= 1'b0;
            wb_dat_o <= '0;
`ifdef L1_INTERCON_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_rty_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Not while a termination is on the bus: the host's strobe
                    // belongs to the transaction it is just completing.
                    if (wb_cyc_i && wb_stb_i && !term_out) begin
                        tgt     <= wb_adr_i[ADR_W-1 -: 2];
                        lat_adr <= wb_adr_i[ADR_W-3:0];
                        lat_dat <= wb_dat_i;
                        lat_sel <= wb_sel_i;
                        lat_we  <= wb_we_i;
                        if (!wb_adr_i[ADR_W-1] && !clock_enabled_i) begin
                            wb_dat_o <= DEAD_DATA;
                            pend_err <= 1'b0;
                            pend_rty <= 1'b0;
                            state    <= ACK;
                        end else begin
                            tgt_cyc <= 4'b0001 << wb_adr_i[ADR_W-1 -: 2];
`ifdef L1_INTERCON_TIMEOUT_EN
                            tmo_cnt <= TMO_W'(TIMEOUT - 1);
`endif
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!wb_cyc_i) begin
                        tgt_cyc <= 4'b0;
                        state   <= IDLE;
                    end else if (sel_ack || sel_err || sel_rty) begin
                        tgt_cyc  <= 4'b0;
                        wb_dat_o <= sel_dat;
                        pend_err <= sel_err;
                        pend_rty <= sel_rty && !sel_err;
                        state    <= ACK;
                    end
`ifdef L1_INTERCON_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        tgt_cyc  <= 4'b0;
                        wb_dat_o <= DEAD_DATA;
                        wb_err_o <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                ACK: begin
                    wb_err_o <= pend_err;
                    wb_rty_o <= pend_rty;
                    wb_ack_o <= !pend_err && !pend_rty;
                    state    <= IDLE;
                end
                default: begin
                    tgt_cyc <= 4'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign thresh_cyc_o  = tgt_cyc[0];
    assign thresh_stb_o  = tgt_cyc[0];
    assign control_cyc_o = tgt_cyc[1];
    assign control_stb_o = tgt_cyc[1];
    assign agc_cyc_o     = tgt_cyc[2];
    assign agc_stb_o     = tgt_cyc[2];
    assign bq_cyc_o      = tgt_cyc[3];
    assign bq_stb_o      = tgt_cyc[3];

    assign thresh_we_o  = lat_we;
    assign control_we_o = lat_we;
    assign agc_we_o     = lat_we;
    assign bq_we_o      = lat_we;

    assign thresh_adr_o  = lat_adr;
    assign control_adr_o = lat_adr;
    assign agc_adr_o     = lat_adr;
    assign bq_adr_o      = lat_adr;

    assign thresh_dat_o  = lat_dat;
    assign control_dat_o = lat_dat;
    assign agc_dat_o     = lat_dat;
    assign bq_dat_o      = lat_dat;

    assign thresh_sel_o  = lat_sel;
    assign control_sel_o = lat_sel;
    assign agc_sel_o     = lat_sel;
    assign bq_sel_o      = lat_sel;

endmodule

// File: tb/tb_l1_trig_wb_intercon.sv
// Directed bench for l1_trig_wb_intercon; covers the L1_INTERCON_TIMEOUT_EN build when that macro is defined.
module tb_l1_trig_wb_intercon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [14:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        ack, err, rty;
    logic [31:0] rdat;

    logic        th_cyc, th_stb, th_we;   logic [12:0] th_adr; logic [31:0] th_do; logic [3:0] th_sel;
    logic        co_cyc, co_stb, co_we;   logic [12:0] co_adr; logic [31:0] co_do; logic [3:0] co_sel;
    logic        ag_cyc, ag_stb, ag_we;   logic [12:0] ag_adr; logic [31:0] ag_do; logic [3:0] ag_sel;
    logic        bq_cyc, bq_stb, bq_we;   logic [12:0] bq_adr; logic [31:0] bq_do; logic [3:0] bq_sel;
    logic th_ack = 0, th_err = 0, th_rty = 0; logic [31:0] th_di = '0;
    logic co_ack = 0, co_err = 0, co_rty = 0; logic [31:0] co_di = '0;
    logic ag_ack = 0, ag_err = 0, ag_rty = 0; logic [31:0] ag_di = '0;
    logic bq_ack = 0, bq_err = 0, bq_rty = 0; logic [31:0] bq_di = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1_trig_wb_intercon dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .clock_enabled_i(clk_en),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(rdat),
        .thresh_cyc_o(th_cyc), .thresh_stb_o(th_stb), .thresh_we_o(th_we), .thresh_adr_o(th_adr),
        .thresh_dat_o(th_do), .thresh_sel_o(th_sel),
        .thresh_ack_i(th_ack), .thresh_err_i(th_err), .thresh_rty_i(th_rty), .thresh_dat_i(th_di),
        .control_cyc_o(co_cyc), .control_stb_o(co_stb), .control_we_o(co_we), .control_adr_o(co_adr),
        .control_dat_o(co_do), .control_sel_o(co_sel),
        .control_ack_i(co_ack), .control_err_i(co_err), .control_rty_i(co_rty), .control_dat_i(co_di),
        .agc_cyc_o(ag_cyc), .agc_stb_o(ag_stb), .agc_we_o(ag_we), .agc_adr_o(ag_adr),
        .agc_dat_o(ag_do), .agc_sel_o(ag_sel),
        .agc_ack_i(ag_ack), .agc_err_i(ag_err), .agc_rty_i(ag_rty), .agc_dat_i(ag_di),
        .bq_cyc_o(bq_cyc), .bq_stb_o(bq_stb), .bq_we_o(bq_we), .bq_adr_o(bq_adr),
        .bq_dat_o(bq_do), .bq_sel_o(bq_sel),
        .bq_ack_i(bq_ack), .bq_err_i(bq_err), .bq_rty_i(bq_rty), .bq_dat_i(bq_di)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive a host request at the current negedge; caller then ticks.
    task automatic host_go(input logic [14:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic host_stop();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rty", rty, 1'b0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_cyc", {th_cyc, co_cyc, ag_cyc, bq_cyc}, 4'b0000);
        rst_n = 1'b1;
        tick();

        // 1: read 0x4010 from agc, ack one cycle after strobe
        host_go(15'h4010, 1'b0, 32'h0, 4'hF);
        tick();
        chk("t1_agc_cyc", {ag_cyc, ag_stb}, 2'b11);
        chk("t1_agc_adr", ag_adr, 13'h0010);
        chk("t1_others_cyc", {th_cyc, co_cyc, bq_cyc}, 3'b000);
        chk("t1_agc_we", ag_we, 1'b0);
        ag_ack = 1'b1; ag_di = 32'h1234_5678;
        tick();
        chk("t1_agc_drop", ag_cyc, 1'b0);
        chk("t1_no_early_ack", ack, 1'b0);
        ag_ack = 1'b0; ag_di = 32'h0;
        tick();
        chk("t1_ack", ack, 1'b1);
        chk("t1_dat", rdat, 32'h1234_5678);
        chk("t1_err_rty", {err, rty}, 2'b00);
        host_stop();
        tick();
        chk("t1_ack_pulse", ack, 1'b0);

        // 2: write 0x6004 to bq, same-cycle ack
        host_go(15'h6004, 1'b1, 32'hA5A5_A5A5, 4'hF);
        tick();
        chk("t2_bq_cyc", bq_cyc, 1'b1);
        chk("t2_bq_we", bq_we, 1'b1);
        chk("t2_bq_dat", bq_do, 32'hA5A5_A5A5);
        chk("t2_bq_adr", bq_adr, 13'h0004);
        chk("t2_bq_sel", bq_sel, 4'hF);
        chk("t2_others_cyc", {th_cyc, co_cyc, ag_cyc}, 3'b000);
        bq_ack = 1'b1;
        tick();
        bq_ack = 1'b0;
        tick();
        chk("t2_ack", ack, 1'b1);
        host_stop();
        tick();

        // 3: clock stopped, control shielded, agc still reached
        clk_en = 1'b0;
        host_go(15'h2000, 1'b0, 32'h0, 4'hF);
        tick();
        chk("t3_ctl_cyc_c1", co_cyc, 1'b0);
        chk("t3_ack_c1", ack, 1'b0);
        tick();
        chk("t3_ack_c2", ack, 1'b1);
        chk("t3_dead", rdat, 32'hDEAD_C10C);
        chk("t3_ctl_cyc_c2", co_cyc, 1'b0);
        host_stop();
        tick();
        chk("t3_ack_pulse", ack, 1'b0);
        host_go(15'h4000, 1'b0, 32'h0, 4'hF);
        tick();
        chk("t3_agc_cyc", ag_cyc, 1'b1);
        ag_ack = 1'b1; ag_di = 32'hCAFE_F00D;
        tick();
        ag_ack = 1'b0;
        tick();
        chk("t3_agc_ack", ack, 1'b1);
        chk("t3_agc_dat", rdat, 32'hCAFE_F00D);
        host_stop();
        tick();
        clk_en = 1'b1;

        // 4: termination priority
        host_go(15'h0008, 1'b0, 32'h0, 4'hF);
        tick();
        chk("t4_th_cyc", th_cyc, 1'b1);
        th_err = 1'b1; th_ack = 1'b1;
        tick();
        th_err = 1'b0; th_ack = 1'b0;
        tick();
        chk("t4_err_over_ack", {err, rty, ack}, 3'b100);
        host_stop();
        tick();
        host_go(15'h2010, 1'b0, 32'h0, 4'hF);
        tick();
        co_rty = 1'b1; co_ack = 1'b1;
        tick();
        co_rty = 1'b0; co_ack = 1'b0;
        tick();
        chk("t4_rty_over_ack", {err, rty, ack}, 3'b010);
        host_stop();
        tick();
        host_go(15'h6000, 1'b0, 32'h0, 4'hF);
        tick();
        bq_rty = 1'b1; bq_err = 1'b1;
        tick();
        bq_rty = 1'b0; bq_err = 1'b0;
        tick();
        chk("t4_err_over_rty", {err, rty, ack}, 3'b100);
        host_stop();
        tick();

        // 5: abort on control, late ack ignored
        host_go(15'h2020, 1'b0, 32'h0, 4'hF);
        tick();
        chk("t5_ctl_cyc", co_cyc, 1'b1);
        host_stop();
        tick();
        chk("t5_ctl_drop", co_cyc, 1'b0);
        co_ack = 1'b1;
        tick();
        tick();
        chk("t5_no_term", {err, rty, ack}, 3'b000);
        co_ack = 1'b0;
        tick();
        chk("t5_no_term2", {err, rty, ack}, 3'b000);

        // clock_enabled drop mid-BUSY does not affect the transaction
        host_go(15'h2030, 1'b0, 32'h0, 4'hF);
        tick();
        clk_en = 1'b0;
        tick();
        chk("t5b_ctl_cyc_held", co_cyc, 1'b1);
        co_ack = 1'b1; co_di = 32'h0BAD_BEEF;
        tick();
        co_ack = 1'b0;
        tick();
        chk("t5b_ack", ack, 1'b1);
        chk("t5b_dat", rdat, 32'h0BAD_BEEF);
        host_stop();
        clk_en = 1'b1;
        tick();

        // async reset mid-transaction
        host_go(15'h4040, 1'b0, 32'h0, 4'hF);
        tick();
        chk("rst_mid_pre", ag_cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_drop", ag_cyc, 1'b0);
        host_stop();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 6: silent agc, non-selected targets responding meanwhile
        host_go(15'h4000, 1'b0, 32'h0, 4'hF);
        tick();
        th_ack = 1'b1; bq_err = 1'b1; co_rty = 1'b1;
`ifdef L1_INTERCON_TIMEOUT_EN
        repeat (255) @(posedge clk);
        @(negedge clk);
        chk("t6_busy_255", {ag_cyc, err, rty, ack}, 4'b1000);
        tick();
        chk("t6_tmo_err", err, 1'b1);
        chk("t6_tmo_drop", ag_cyc, 1'b0);
        chk("t6_tmo_dat", rdat, 32'hDEAD_C10C);
        host_stop();
        tick();
        chk("t6_err_pulse", err, 1'b0);
`else
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("t6_still_busy", ag_cyc, 1'b1);
        chk("t6_no_term", {err, rty, ack}, 3'b000);
        host_stop();
        tick();
        chk("t6_abort_drop", ag_cyc, 1'b0);
`endif
        th_ack = 1'b0; bq_err = 1'b0; co_rty = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
